// File: rtl/cmd_sender.sv
// cmd_sender: serializes {cmd, data[15:8], data[7:0]} as three 8N1 bytes on TX
// and receives single-byte responses on RX.
// Optional response watchdog is built when CMD_SENDER_TIMEOUT_EN is defined.
module cmd_sender #(
    parameter int BAUD_DIV    = 2604,
    parameter int TIMEOUT_CYC = 1 << 22
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snd_cmd,
    input  logic [7:0]  cmd,
    input  logic [15:0] data,
    input  logic        clr_resp_rdy,
    input  logic        RX,
    output logic        TX,
    output logic        busy,
    output logic        cmd_sent,
    output logic [7:0]  resp,
    output logic        resp_rdy,
    output logic        timeout
);

    localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
    localparam logic [11:0] HALF_LAST = 12'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, BITS, STOP} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA} rx_state_t;

    tx_state_t   state, state_nxt;
    logic [23:0] shadow;
    logic [7:0]  tx_shift;
    logic [11:0] baud_cnt, bit_cnt;
    logic [1:0]  byte_idx;
    logic        tick, accept, frame_done, tx_bit, done_q;

    rx_state_t   rstate, rstate_nxt;
    logic        rx_s1, rx_s2, rx_prev, rx_fall, rx_done;
    logic [11:0] rx_cnt, rx_bit;
    logic [7:0]  rx_shift;

    assign tick    = (baud_cnt == BAUD_LAST);
    assign rx_fall = rx_prev & ~rx_s2;

    // TX state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // TX next state and the line level of the current bit
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        frame_done = 1'b0;
        tx_bit     = 1'b1;
        case (state)
            IDLE: if (snd_cmd) begin
                accept    = 1'b1;
                state_nxt = START;
            end
            START: begin
                tx_bit = 1'b0;
                if (tick) state_nxt = BITS;
            end
            BITS: begin
                tx_bit = tx_shift[0];
                if (tick && bit_cnt == 12'd8) state_nxt = STOP;
            end
            STOP: if (tick) begin
                if (byte_idx == 2'd2) begin
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                end else begin
                    state_nxt = START;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // TX datapath: baud/bit counters, shadow capture, byte selection and shifting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            shadow   <= '0;
            tx_shift <= '0;
        end else begin
            if (state == IDLE || tick) baud_cnt <= '0;
            else                       baud_cnt <= baud_cnt + 12'd1;

            // bit_cnt walks start(0), data(1..8), stop(9) within each byte
            if (state == IDLE) bit_cnt <= '0;
            else if (tick)     bit_cnt <= (bit_cnt == 12'd9) ? 12'd0 : bit_cnt + 12'd1;

            if (accept) begin
                shadow   <= {cmd, data};
                tx_shift <= cmd;
                byte_idx <= 2'd0;
            end else if (state == BITS && tick) begin
                tx_shift <= {1'b0, tx_shift[7:1]};
            end else if (state == STOP && tick && byte_idx != 2'd2) begin
                byte_idx <= byte_idx + 2'd1;
                tx_shift <= (byte_idx == 2'd0) ? shadow[15:8] : shadow[7:0];
            end
        end
    end

    // TX outputs: the line is registered once, so busy/cmd_sent trail the FSM by one extra cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            TX       <= 1'b1;
            done_q   <= 1'b0;
            cmd_sent <= 1'b0;
            busy     <= 1'b0;
        end else begin
            TX       <= tx_bit;
            done_q   <= frame_done;
            cmd_sent <= done_q;
            if (accept)      busy <= 1'b1;
            else if (done_q) busy <= 1'b0;
        end
    end

    // RX synchronizer and previous-sample flop for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= RX;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // RX state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rstate <= R_IDLE;
        else        rstate <= rstate_nxt;
    end

    // RX next state: confirm start mid-bit, then nine full-period samples (8 data + stop)
    always_comb begin
        rstate_nxt = rstate;
        rx_done    = 1'b0;
        case (rstate)
            R_IDLE:  if (rx_fall) rstate_nxt = R_START;
            R_START: if (rx_cnt == HALF_LAST) rstate_nxt = rx_s2 ? R_IDLE : R_DATA;
            R_DATA:  if (rx_cnt == BAUD_LAST && rx_bit == 12'd8) begin
                rx_done    = 1'b1;
                rstate_nxt = R_IDLE;
            end
            default: rstate_nxt = R_IDLE;
        endcase
    end

    // RX counters and LSB-first shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            case (rstate)
                R_START: begin
                    rx_cnt <= (rx_cnt == HALF_LAST) ? 12'd0 : rx_cnt + 12'd1;
                    rx_bit <= '0;
                end
                R_DATA: begin
                    if (rx_cnt == BAUD_LAST) begin
                        rx_cnt <= '0;
                        rx_bit <= rx_bit + 12'd1;
                        if (rx_bit != 12'd8) rx_shift <= {rx_s2, rx_shift[7:1]};
                    end else begin
                        rx_cnt <= rx_cnt + 12'd1;
                    end
                end
                default: begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
                end
            endcase
        end
    end

    // Response register; a completing byte beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp     <= 8'h00;
            resp_rdy <= 1'b0;
        end else begin
            if (rx_done) begin
                resp     <= rx_shift;
                resp_rdy <= 1'b1;
            end else if (clr_resp_rdy || accept) begin
                resp_rdy <= 1'b0;
            end
        end
    end

`ifdef CMD_SENDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt;
    logic          to_run;

    // Response watchdog: armed by cmd_sent, disarmed by a response or a new command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt  <= '0;
            to_run  <= 1'b0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (accept || resp_rdy) begin
                to_run <= 1'b0;
                to_cnt <= '0;
            end else if (cmd_sent) begin
                to_run <= 1'b1;
                to_cnt <= TW'(1);
            end else if (to_run) begin
                if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    timeout <= 1'b1;
                    to_run  <= 1'b0;
                end else begin
                    to_cnt <= to_cnt + TW'(1);
                end
            end
        end
    end
`else
    // No watchdog: constant 0 (the parameter is only compared so it stays referenced)
    assign timeout = (TIMEOUT_CYC < 0);
`endif

endmodule

// File: tb/tb_cmd_sender.sv
// Self-checking bench for cmd_sender at BAUD_DIV=8: TX bytes are decoded by a
// line monitor and matched against a queue of expected bytes; RX responses are
// matched against a second queue.
module tb_cmd_sender;

    localparam int B = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        snd_cmd = 1'b0;
    logic [7:0]  cmd = 8'h00;
    logic [15:0] data = 16'h0000;
    logic        clr_resp_rdy = 1'b0;
    logic        RX = 1'b1;
    logic        TX, busy, cmd_sent, resp_rdy, timeout;
    logic [7:0]  resp;

    int total = 0;
    int bad = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic rst_seen = 1'b0;

    cmd_sender #(.BAUD_DIV(B), .TIMEOUT_CYC(100)) dut (
        .clk(clk), .rst_n(rst_n), .snd_cmd(snd_cmd), .cmd(cmd), .data(data),
        .clr_resp_rdy(clr_resp_rdy), .RX(RX), .TX(TX), .busy(busy),
        .cmd_sent(cmd_sent), .resp(resp), .resp_rdy(resp_rdy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(negedge rst_n) rst_seen = 1'b1;

    // TX line monitor: finds a start bit, samples each bit mid-period, checks against tx_q
    initial begin : tx_mon
        logic [7:0] b;
        logic [7:0] e;
        logic prev;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && prev === 1'b1 && TX === 1'b0) begin
                rst_seen = 1'b0;
                repeat (B/2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (B) @(negedge clk);
                    b[i] = TX;
                end
                repeat (B) @(negedge clk);
                if (!rst_seen) begin
                    total++;
                    if (TX !== 1'b1) begin
                        bad++;
                        $display("FAIL tx_stop: got %b want 1", TX);
                    end
                    total++;
                    if (tx_q.size() == 0) begin
                        bad++;
                        $display("FAIL tx_byte: got %02h, none expected", b);
                    end else begin
                        e = tx_q.pop_front();
                        if (b !== e) begin
                            bad++;
                            $display("FAIL tx_byte: got %02h want %02h", b, e);
                        end
                    end
                end
            end
            prev = TX;
        end
    end

    task automatic drive_rx(input logic [7:0] b);
        RX = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (B) @(negedge clk);
        end
        RX = 1'b1;
        repeat (B) @(negedge clk);
    endtask

    task automatic issue(input logic [7:0] c, input logic [15:0] d, input bit expect_bytes);
        @(negedge clk);
        cmd = c; data = d; snd_cmd = 1'b1;
        if (expect_bytes) begin
            tx_q.push_back(c); tx_q.push_back(d[15:8]); tx_q.push_back(d[7:0]);
        end
        @(negedge clk);
        snd_cmd = 1'b0;
    endtask

    task automatic wait_cmd_sent(input int bound);
        int n = 0;
        while (cmd_sent !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (cmd_sent !== 1'b1) begin
            bad++;
            $display("FAIL cmd_sent_wait: got %b want 1 within %0d cycles", cmd_sent, bound);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (tx_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (tx_q.size() != 0) begin
            bad++;
            $display("FAIL tx_drain: %0d bytes still expected, want 0", tx_q.size());
        end
    endtask

    task automatic check_resp();
        logic [7:0] e;
        total++;
        if (rx_q.size() == 0) begin
            bad++;
            $display("FAIL resp: got %02h, none expected", resp);
        end else begin
            e = rx_q.pop_front();
            if (resp !== e) begin
                bad++;
                $display("FAIL resp: got %02h want %02h", resp, e);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total += 6;
        if (TX !== 1'b1)       begin bad++; $display("FAIL reset_tx: got %b want 1", TX); end
        if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (cmd_sent !== 1'b0) begin bad++; $display("FAIL reset_cmd_sent: got %b want 0", cmd_sent); end
        if (resp !== 8'h00)    begin bad++; $display("FAIL reset_resp: got %02h want 00", resp); end
        if (resp_rdy !== 1'b0) begin bad++; $display("FAIL reset_resp_rdy: got %b want 0", resp_rdy); end
        if (timeout !== 1'b0)  begin bad++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Frame timing: TX low after edge 1, busy through edge 240, cmd_sent after edge 241
    task automatic test_send();
        issue(8'h02, 16'h0001, 1'b1);
        for (int k = 1; k <= 242; k++) begin
            @(negedge clk);
            if (k == 1) begin
                total++;
                if (TX !== 1'b0) begin bad++; $display("FAIL send_tx_start: got %b want 0 at edge 1", TX); end
            end
            total += 2;
            if (cmd_sent !== (k == 241)) begin
                bad++; $display("FAIL send_cmd_sent: got %b want %b at edge %0d", cmd_sent, (k == 241), k);
            end
            if (busy !== (k <= 240)) begin
                bad++; $display("FAIL send_busy: got %b want %b at edge %0d", busy, (k <= 240), k);
            end
        end
        wait_drain();
    endtask

    // Ignored request mid-frame, then the earliest legal follow-on request
    task automatic test_back_to_back();
        issue(8'h02, 16'h0800, 1'b1);
        repeat (99) @(negedge clk);
        cmd = 8'h05; data = 16'hFFFF; snd_cmd = 1'b1;
        @(negedge clk);
        snd_cmd = 1'b0; cmd = 8'h00; data = 16'h0000;
        repeat (140) @(negedge clk);
        cmd = 8'h02; data = 16'h801C; snd_cmd = 1'b1;
        tx_q.push_back(8'h02); tx_q.push_back(8'h80); tx_q.push_back(8'h1C);
        @(negedge clk);
        snd_cmd = 1'b0;
        total += 2;
        if (cmd_sent !== 1'b1) begin bad++; $display("FAIL b2b_cmd_sent: got %b want 1 at edge 241", cmd_sent); end
        if (TX !== 1'b1)       begin bad++; $display("FAIL b2b_tx_idle: got %b want 1 at edge 241", TX); end
        @(negedge clk);
        total++;
        if (TX !== 1'b0) begin bad++; $display("FAIL b2b_tx_start: got %b want 0 at edge 242", TX); end
        wait_cmd_sent(300);
        wait_drain();
    endtask

    task automatic test_rx();
        int n;
        bit got, seen;
        rx_q.push_back(8'hA5);
        n = 0; got = 1'b0;
        fork
            drive_rx(8'hA5);
            begin
                while (n < 120 && !got) begin
                    @(negedge clk);
                    n++;
                    if (resp_rdy === 1'b1) got = 1'b1;
                end
            end
        join
        total++;
        if (!got || n > 79) begin bad++; $display("FAIL rx_latency: got %0d cycles (seen=%b) want <=79", n, got); end
        check_resp();
        total++;
        if (resp_rdy !== 1'b1) begin bad++; $display("FAIL rx_hold: got %b want 1", resp_rdy); end
        clr_resp_rdy = 1'b1;
        @(negedge clk);
        clr_resp_rdy = 1'b0;
        total++;
        if (resp_rdy !== 1'b0) begin bad++; $display("FAIL rx_clear: got %b want 0", resp_rdy); end
        // two-clock glitch must not produce a byte
        RX = 1'b0;
        repeat (2) @(negedge clk);
        RX = 1'b1;
        seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (resp_rdy !== 1'b0) seen = 1'b1;
        end
        total += 2;
        if (seen)           begin bad++; $display("FAIL rx_glitch: got resp_rdy 1 want 0"); end
        if (resp !== 8'hA5) begin bad++; $display("FAIL rx_glitch_resp: got %02h want a5", resp); end
        // completion coinciding with a held clear: set wins
        rx_q.push_back(8'h3C);
        clr_resp_rdy = 1'b1;
        seen = 1'b0;
        fork
            drive_rx(8'h3C);
            begin
                repeat (100) begin
                    @(negedge clk);
                    if (resp_rdy === 1'b1) seen = 1'b1;
                end
            end
        join
        clr_resp_rdy = 1'b0;
        total++;
        if (!seen) begin bad++; $display("FAIL rx_set_wins: got resp_rdy 0 want 1"); end
        check_resp();
    endtask

    task automatic test_resp_clear_on_send();
        rx_q.push_back(8'h5A);
        @(negedge clk);
        drive_rx(8'h5A);
        check_resp();
        total++;
        if (resp_rdy !== 1'b1) begin bad++; $display("FAIL pre_send_rdy: got %b want 1", resp_rdy); end
        issue(8'h02, 16'h0001, 1'b1);
        total++;
        if (resp_rdy !== 1'b0) begin bad++; $display("FAIL send_clears_rdy: got %b want 0", resp_rdy); end
        wait_cmd_sent(300);
        wait_drain();
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge clk);
        cmd = 8'h02; data = 16'h1234; snd_cmd = 1'b1;
        tx_q.push_back(8'h02);
        @(negedge clk);
        snd_cmd = 1'b0;
        repeat (120) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total += 3;
        if (TX !== 1'b1)       begin bad++; $display("FAIL rst_mid_tx: got %b want 1", TX); end
        if (busy !== 1'b0)     begin bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        if (cmd_sent !== 1'b0) begin bad++; $display("FAIL rst_mid_cmd_sent: got %b want 0", cmd_sent); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (cmd_sent !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen) begin bad++; $display("FAIL rst_mid_no_sent: got cmd_sent 1 want 0"); end
        wait_drain();
        issue(8'h02, 16'hABCD, 1'b1);
        wait_cmd_sent(300);
        wait_drain();
    endtask

    task automatic test_timeout();
        int pulses, first;
        issue(8'h02, 16'h0001, 1'b1);
        wait_cmd_sent(300);
        pulses = 0; first = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (timeout === 1'b1) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
`ifdef CMD_SENDER_TIMEOUT_EN
        total += 2;
        if (pulses != 1) begin bad++; $display("FAIL timeout_pulses: got %0d want 1", pulses); end
        if (first != 100) begin bad++; $display("FAIL timeout_delay: got %0d want 100", first); end
        issue(8'h02, 16'h0002, 1'b1);
        wait_cmd_sent(300);
        rx_q.push_back(8'hA5);
        pulses = 0;
        fork
            begin
                repeat (10) @(negedge clk);
                drive_rx(8'hA5);
            end
            begin
                for (int k = 1; k <= 200; k++) begin
                    @(negedge clk);
                    if (timeout === 1'b1) pulses++;
                end
            end
        join
        total++;
        if (pulses != 0) begin bad++; $display("FAIL timeout_answered: got %0d pulses want 0", pulses); end
        check_resp();
`else
        total++;
        if (pulses != 0) begin bad++; $display("FAIL timeout_tied: got %0d pulses want 0", pulses); end
`endif
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_send();
        test_back_to_back();
        test_rx();
        test_resp_clear_on_send();
        test_reset_mid();
        test_timeout();
        total += 2;
        if (tx_q.size() != 0) begin bad++; $display("FAIL tx_q_left: got %0d want 0", tx_q.size()); end
        if (rx_q.size() != 0) begin bad++; $display("FAIL rx_q_left: got %0d want 0", rx_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmd_sender.md
# cmd_sender

Host-side command transmitter that serializes a framed command (one opcode byte plus a 16-bit payload) onto a UART TX line for the quadcopter's UART command wrapper and `cmd_cfg` stage. It also receives the single-byte acknowledge (e.g. posack 0xA5) on the RX line. It is the upstream stage that drives the command path exercised by the pitch/roll/yaw/thrust command benches. It contains its own 8N1 transmitter and receiver; no external UART is needed.

## Interface
- BAUD_DIV, 2604, clocks per bit (19200 baud at 50 MHz); legal range 8..4095.
- TIMEOUT_CYC, 2^22, clocks allowed from `cmd_sent` to response before `timeout` fires; used only with CMD_SENDER_TIMEOUT_EN.
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- snd_cmd  input  1  one-cycle request to send `cmd`/`data`.
- cmd  input  8  opcode byte, captured with `snd_cmd`.
- data  input  16  payload, captured with `snd_cmd`.
- clr_resp_rdy  input  1  clears `resp_rdy`.
- RX  input  1  serial response line, asynchronous, idles high.
- TX  output  1  serial command line, idles high.
- busy  output  1  high while a frame is being transmitted.
- cmd_sent  output  1  one-cycle pulse when the third byte's stop bit completes.
- resp  output  8  last received byte.
- resp_rdy  output  1  set on byte received; held until cleared.
- timeout  output  1  one-cycle pulse when no response arrives in time.

## Operation
- Reset values: TX=1, busy=0, cmd_sent=0, resp=8'h00, resp_rdy=0, timeout=0. Every FSM returns to IDLE and every counter to 0.
- TX FSM states: IDLE, START, BITS, STOP.
  - IDLE: `snd_cmd` latches {cmd, data} into a 24-bit shadow register, sets `busy`, sets byte index 0, and goes to START.
  - `snd_cmd` while `busy`=1 is ignored. The shadow register is not disturbed.
- Byte order on the line: cmd, data[15:8], data[7:0]. Each byte is framed as start(0), 8 data bits LSB first, stop(1). Each bit is held exactly BAUD_DIV clocks.
- Bytes are sent back-to-back with no idle gap. After the third stop bit: `busy`=0, `cmd_sent` pulses, FSM goes to IDLE.
- `snd_cmd` in IDLE also clears `resp_rdy`, so a stale ack is never read as the new one.
- RX path:
  - RX passes through a two-flop synchronizer (metastability), then falling-edge detection.
  - Start is confirmed at BAUD_DIV/2. Each data bit and the stop bit are sampled at BAUD_DIV intervals after that.
  - If the line is high at the start-bit check, the event is a glitch: abort to idle, no output change.
  - At the stop-bit sample: `resp` ← shifted byte and `resp_rdy`=1, whatever the stop-bit value.
- The RX path runs independently of TX; reception during transmission is legal.
- Simultaneous `clr_resp_rdy` and byte completion: the set wins.
- Reset mid-frame aborts immediately: TX=1 asynchronously, partial byte discarded, no `cmd_sent`.

## Timing
- `snd_cmd` sampled high at edge 0 → TX low from edge 1.
- `cmd_sent` high during the cycle starting at edge 30·BAUD_DIV+1; `busy` falls at the same edge.
- Earliest accepted next `snd_cmd` is at edge 30·BAUD_DIV+1. It produces TX low on the following edge.
- RX: `resp_rdy` rises at most BAUD_DIV/2 + 9·BAUD_DIV + 3 clocks after the RX falling edge. The 3 includes the synchronizer.
- Baud and bit counters are sized at 12 bits; the bit counter wraps at 10 per byte and the byte index at 3.

## Configuration
- CMD_SENDER_TIMEOUT_EN defined:
  - A counter starts at `cmd_sent` and stops on `resp_rdy` or a new `snd_cmd`.
  - On reaching TIMEOUT_CYC it pulses `timeout` for one cycle and stops. It does not retransmit.
- CMD_SENDER_TIMEOUT_EN undefined: no counter is built; `timeout` is tied to 0.

## Test plan
- BAUD_DIV=8, `snd_cmd` with cmd=8'h02, data=16'h0001 → TX decodes to 02, 00, 01; `cmd_sent` pulses at edge 241; `busy` high for edges 1–240.
- Send 8'h02/16'h0800, then pulse `snd_cmd` with 8'h05/16'hFFFF at edge 100 → ignored; line carries 02, 08, 00 only. A third send at edge 241 of 8'h02/16'h801C → 02, 80, 1C.
- Drive RX with 0xA5 at BAUD_DIV=8 → `resp`=8'hA5 and `resp_rdy`=1 within 79 clocks. `clr_resp_rdy` → 0 next edge. A 2-clock RX low glitch → no `resp_rdy`.
- Assert `rst_n`=0 during the second byte → TX=1 immediately; `busy`=0; no `cmd_sent`. The next send completes normally.
- With CMD_SENDER_TIMEOUT_EN and TIMEOUT_CYC=100, send with no RX activity → `timeout` pulses exactly once, 100 clocks after `cmd_sent`. Returning 0xA5 earlier → no pulse.
- Keep `resp_rdy`=1 from a previous ack, then issue `snd_cmd` → `resp_rdy` clears at the next edge.
